// File: rtl/siggen_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : siggen_burst_ctrl
//  Purpose  : Packetizes a free-running sample stream into bursts of
//             packets. Packet length comes from pkt_len. Packets per burst,
//             the inter-burst gap and the control bits are programmed over
//             the settings bus. In RUN the stream passes through
//             combinationally. In IDLE and GAP the stream is held off.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset_n                  clock, asynchronous active-low reset
//    set_stb/set_addr/set_data     settings bus (registers update one
//                                  cycle after the strobe)
//    pkt_len                       samples per packet (0 behaves as 1)
//    i_tdata/i_tvalid/i_tready     sample stream in
//    o_tdata/o_tlast/o_tvalid/     packetized stream out
//    o_tready
//    o_eob                         marks the final o_tlast of a burst
//    busy                          state is not IDLE
//    rb_status                     status readback word
//  Configuration
//    SIGGEN_BURST_STATUS_EN        when defined, rb_status reports the
//                                  state and a saturating count of
//                                  completed bursts; otherwise it reads 0
// ============================================================================
module siggen_burst_ctrl #(
    parameter int SR_BURST_PKTS = 150,
    parameter int SR_BURST_GAP  = 151,
    parameter int SR_BURST_CTRL = 152
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [15:0] pkt_len,
    input  logic [31:0] i_tdata,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        o_eob,
    output logic        busy,
    output logic [31:0] rb_status
);

    localparam logic [7:0] ADDR_PKTS = 8'(SR_BURST_PKTS);
    localparam logic [7:0] ADDR_GAP  = 8'(SR_BURST_GAP);
    localparam logic [7:0] ADDR_CTRL = 8'(SR_BURST_CTRL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Settings registers
    // ------------------------------------------------------------------
    logic [15:0] pkts_q;
    logic [15:0] gap_q;
    logic        cont_q;
    logic        start_q;
    logic        stop_q;

    logic w_wr_pkts;
    logic w_wr_gap;
    logic w_wr_ctrl;

    assign w_wr_pkts = set_stb && (set_addr == ADDR_PKTS);
    assign w_wr_gap  = set_stb && (set_addr == ADDR_GAP);
    assign w_wr_ctrl = set_stb && (set_addr == ADDR_CTRL);

    // Upper settings bits carry no meaning for this block.
    logic unused_set_data;
    assign unused_set_data = &{1'b0, set_data[31:16]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkts_q  <= 16'd1;
            gap_q   <= 16'd0;
            cont_q  <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            // Stop wins when both command bits arrive on one strobe.
            start_q <= w_wr_ctrl && set_data[0] && !set_data[1];
            stop_q  <= w_wr_ctrl && set_data[1];
            if (w_wr_pkts) pkts_q <= set_data[15:0];
            if (w_wr_gap)  gap_q  <= set_data[15:0];
            if (w_wr_ctrl) cont_q <= set_data[2];
        end
    end

    // ------------------------------------------------------------------
    // Burst state machine
    // ------------------------------------------------------------------
    state_t      state_q,      state_d;
    logic [15:0] sample_cnt_q, sample_cnt_d;
    logic [15:0] pkt_cnt_q,    pkt_cnt_d;
    logic [15:0] gap_cnt_q,    gap_cnt_d;
    logic [15:0] len_q,        len_d;
    logic [15:0] pkts_lat_q,   pkts_lat_d;
    logic        stop_pend_q,  stop_pend_d;

    logic        w_run;
    logic        w_beat;
    logic        w_pkt_start;
    logic [15:0] w_len_eff;
    logic [15:0] w_pkts_eff;
    logic [15:0] w_len;
    logic [15:0] w_pkts;
    logic        w_last_sample;
    logic        w_stop;
    logic        w_last_pkt;

    assign w_run       = (state_q == RUN);
    assign w_beat      = w_run && i_tvalid && o_tready;
    assign w_pkt_start = (sample_cnt_q == 16'd0);
    assign w_len_eff   = (pkt_len == 16'd0) ? 16'd1 : pkt_len;
    assign w_pkts_eff  = (pkts_q  == 16'd0) ? 16'd1 : pkts_q;

    // While no sample of the packet has moved yet, the live settings
    // apply. Once the first beat is taken, the latched copies govern the
    // rest of the packet.
    assign w_len  = w_pkt_start ? w_len_eff  : len_q;
    assign w_pkts = w_pkt_start ? w_pkts_eff : pkts_lat_q;

    assign w_last_sample = (sample_cnt_q == (w_len - 16'd1));
    assign w_stop        = stop_q || stop_pend_q;
    // The >= compare keeps a burst from overrunning if the packet count
    // is lowered below the packets already sent.
    assign w_last_pkt    = w_stop || (pkt_cnt_q >= (w_pkts - 16'd1));

    assign o_tvalid = w_run && i_tvalid;
    assign i_tready = w_run && o_tready;
    assign o_tdata  = w_run ? i_tdata : 32'd0;
    assign o_tlast  = o_tvalid && w_last_sample;
    assign o_eob    = o_tlast && w_last_pkt;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sample_cnt_q <= 16'd0;
            pkt_cnt_q    <= 16'd0;
            gap_cnt_q    <= 16'd0;
            len_q        <= 16'd0;
            pkts_lat_q   <= 16'd0;
            stop_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            len_q        <= len_d;
            pkts_lat_q   <= pkts_lat_d;
            stop_pend_q  <= stop_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        len_d        = len_q;
        pkts_lat_d   = pkts_lat_q;
        stop_pend_d  = stop_pend_q;

        case (state_q)
            IDLE: begin
                if (start_q) begin
                    state_d      = RUN;
                    sample_cnt_d = 16'd0;
                    pkt_cnt_d    = 16'd0;
                    gap_cnt_d    = 16'd0;
                    stop_pend_d  = 1'b0;
                end
            end

            RUN: begin
                if (w_beat) begin
                    if (w_pkt_start) begin
                        len_d      = w_len_eff;
                        pkts_lat_d = w_pkts_eff;
                    end
                    if (w_last_sample) begin
                        sample_cnt_d = 16'd0;
                        if (w_last_pkt) begin
                            pkt_cnt_d = 16'd0;
                            if (w_stop || !cont_q) begin
                                state_d     = IDLE;
                                stop_pend_d = 1'b0;
                            end else if (gap_q != 16'd0) begin
                                state_d   = GAP;
                                gap_cnt_d = 16'd0;
                            end
                        end else begin
                            pkt_cnt_d = pkt_cnt_q + 16'd1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 16'd1;
                        if (stop_q) stop_pend_d = 1'b1;
                    end
                end else if (stop_q) begin
                    // Between packets a stop ends the burst at once;
                    // mid-packet it waits for the packet to complete.
                    if (w_pkt_start) begin
                        state_d   = IDLE;
                        pkt_cnt_d = 16'd0;
                    end else begin
                        stop_pend_d = 1'b1;
                    end
                end
            end

            GAP: begin
                if (stop_q) begin
                    state_d   = IDLE;
                    gap_cnt_d = 16'd0;
                end else if (({1'b0, gap_cnt_q} + 17'd1) >= {1'b0, gap_q}) begin
                    state_d   = RUN;
                    gap_cnt_d = 16'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status readback
    // ------------------------------------------------------------------
`ifdef SIGGEN_BURST_STATUS_EN
    logic [15:0] bursts_done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bursts_done_q <= 16'd0;
        end else if (o_eob && w_beat && (bursts_done_q != 16'hFFFF)) begin
            bursts_done_q <= bursts_done_q + 16'd1;
        end
    end

    assign rb_status = {state_q, 14'd0, bursts_done_q};
`else
    assign rb_status = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_siggen_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_siggen_burst_ctrl
//  Purpose  : Self-checking bench for siggen_burst_ctrl. A table of burst
//             shapes, hand sequences for continuous mode, stop and reset,
//             and randomized backpressure. The reference model derives
//             every beat's data, o_tlast and o_eob from its index in the
//             burst.
//  Revision : 1.0  initial release
// ============================================================================
module tb_siggen_burst_ctrl;

    localparam logic [7:0] A_PKTS = 8'd150;
    localparam logic [7:0] A_GAP  = 8'd151;
    localparam logic [7:0] A_CTRL = 8'd152;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [15:0] pkt_len;
    logic [31:0] i_tdata;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic        o_eob;
    logic        busy;
    logic [31:0] rb_status;

    always #5 clk = ~clk;

    siggen_burst_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .pkt_len   (pkt_len),
        .i_tdata   (i_tdata),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
        .o_tdata   (o_tdata),
        .o_tlast   (o_tlast),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .o_eob     (o_eob),
        .busy      (busy),
        .rb_status (rb_status)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        last;
        logic        eob;
    } beat_t;

    typedef struct {
        int len;
        int pk;
        int exp_beats;
        int exp_lasts;
    } vec_t;

    int          n_checks = 0;
    int          n_err    = 0;
    int unsigned data_ctr = 0;
    int unsigned src_limit = 32'hFFFF_FFFF;
    bit          rand_v = 1'b0;
    bit          rand_r = 1'b0;
    beat_t       beats[$];
    logic        last_busy;
    logic        last_tvalid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_src();
        i_tdata  = data_ctr;
        i_tvalid = (data_ctr < src_limit) && (rand_v ? ($urandom_range(0, 1) == 1) : 1'b1);
        o_tready = rand_r ? ($urandom_range(0, 1) == 1) : 1'b1;
    endtask

    // One clock: sample outputs at the falling edge, then present new
    // inputs just after the rising edge.
    task automatic step();
        @(negedge clk);
        last_busy   = busy;
        last_tvalid = o_tvalid;
        if (o_tvalid && o_tready) begin
            beats.push_back('{d: o_tdata, last: o_tlast, eob: o_eob});
            data_ctr++;
        end
        @(posedge clk);
        #1;
        set_stb = 1'b0;
        drive_src();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        step();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (last_busy && n < budget);
        chk({tag, " idle"}, 64'(last_busy), 64'd0);
    endtask

    task automatic wait_beats(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while (beats.size() < cnt && n < budget) begin
            step();
            n++;
        end
        chk({tag, " beats_seen"}, 64'(beats.size()), 64'(cnt));
    endtask

    // Reference: beat k of an L x P burst carries base+k, is last when
    // (k+1) is a multiple of L, and is end-of-burst on the final beat.
    task automatic expect_burst(input string tag, input int unsigned base, input int len, input int pk);
        int L;
        int P;
        int n;
        L = (len == 0) ? 1 : len;
        P = (pk == 0) ? 1 : pk;
        n = L * P;
        chk({tag, " nbeats"}, 64'(beats.size()), 64'(n));
        for (int k = 0; k < beats.size(); k++) begin
            logic [63:0] e;
            e = {30'd0, 32'(base + 32'(k)), (((k + 1) % L) == 0), ((k + 1) == n)};
            chk({tag, " beat"}, {30'd0, beats[k]}, e);
        end
    endtask

    task automatic run_burst(input string tag, input int len, input int pk, input int budget);
        int unsigned base;
        pkt_len = 16'(len);
        wr(A_PKTS, 32'(pk));
        beats.delete();
        base = data_ctr;
        wr(A_CTRL, 32'h1);
        step();
        wait_idle(tag, budget);
        expect_burst(tag, base, len, pk);
    endtask

    vec_t tbl[6];

    initial begin
        int unsigned base;
        int lasts;
        int eobs;

        tbl[0] = '{4, 3, 12, 3};
        tbl[1] = '{0, 0, 1, 1};
        tbl[2] = '{1, 4, 4, 4};
        tbl[3] = '{3, 1, 3, 1};
        tbl[4] = '{2, 0, 2, 1};
        tbl[5] = '{5, 2, 10, 2};

        reset_n  = 1'b0;
        set_stb  = 1'b0;
        set_addr = 8'd0;
        set_data = 32'd0;
        pkt_len  = 16'd4;
        i_tdata  = 32'd0;
        i_tvalid = 1'b1;
        o_tready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst o_tvalid",  64'(o_tvalid),  64'd0);
        chk("rst o_tlast",   64'(o_tlast),   64'd0);
        chk("rst o_eob",     64'(o_eob),     64'd0);
        chk("rst i_tready",  64'(i_tready),  64'd0);
        chk("rst busy",      64'(busy),      64'd0);
        chk("rst rb_status", 64'(rb_status), 64'd0);
        reset_n = 1'b1;
        drive_src();
        step();

        // Table of burst shapes, unthrottled stream
        for (int i = 0; i < 6; i++) begin
            run_burst($sformatf("tbl%0d", i), tbl[i].len, tbl[i].pk, 200);
            lasts = 0;
            eobs  = 0;
            foreach (beats[k]) begin
                lasts += int'(beats[k].last);
                eobs  += int'(beats[k].eob);
            end
            chk($sformatf("tbl%0d count", i), 64'(beats.size()), 64'(tbl[i].exp_beats));
            chk($sformatf("tbl%0d lasts", i), 64'(lasts), 64'(tbl[i].exp_lasts));
            chk($sformatf("tbl%0d eobs", i),  64'(eobs),  64'd1);
        end

        // Continuous mode with a 5-cycle gap
        pkt_len = 16'd2;
        wr(A_PKTS, 32'd2);
        wr(A_GAP, 32'd5);
        beats.delete();
        wr(A_CTRL, 32'h5);
        step();
        for (int c = 0; c < 18; c++) begin
            step();
            chk($sformatf("cont tvalid c%0d", c), 64'(last_tvalid), 64'((c % 9) < 4));
        end
        chk("cont nbeats", 64'(beats.size()), 64'd8);
        if (beats.size() == 8) begin
            chk("cont eob1", 64'(beats[3].eob), 64'd1);
            chk("cont eob2", 64'(beats[7].eob), 64'd1);
            chk("cont no_eob", 64'(beats[1].eob), 64'd0);
        end
`ifdef SIGGEN_BURST_STATUS_EN
        chk("cont rb_status", 64'(rb_status), 64'h4000_0002);
`else
        chk("cont rb_status", 64'(rb_status), 64'd0);
`endif
        wr(A_CTRL, 32'h2);
        wait_idle("cont stop", 50);
        chk("cont stop nbeats", 64'(beats.size()), 64'd10);
        if (beats.size() > 0)
            chk("cont stop tail", 64'({beats[$].last, beats[$].eob}), 64'b11);

        // Zero values in continuous mode: every beat ends a burst
        pkt_len = 16'd0;
        wr(A_PKTS, 32'd0);
        wr(A_GAP, 32'd0);
        beats.delete();
        wr(A_CTRL, 32'h5);
        step();
        repeat (6) step();
        chk("zero nbeats", 64'(beats.size()), 64'd6);
        foreach (beats[k])
            chk("zero last_eob", 64'({beats[k].last, beats[k].eob}), 64'b11);
        wr(A_CTRL, 32'h2);
        wait_idle("zero stop", 20);

        // Stop after beat 3 of an 8-sample packet
        pkt_len = 16'd8;
        wr(A_PKTS, 32'd1);
        beats.delete();
        base = data_ctr;
        src_limit = base + 3;
        wr(A_CTRL, 32'h1);
        step();
        wait_beats("mid", 3, 40);
        step();
        step();
        chk("mid stalled beats", 64'(beats.size()), 64'd3);
        wr(A_CTRL, 32'h2);
        step();
        step();
        chk("mid busy after stop", 64'(last_busy), 64'd1);
        src_limit = 32'hFFFF_FFFF;
        wait_idle("mid", 40);
        expect_burst("mid", base, 8, 1);

        // Randomized backpressure on both sides
        rand_v = 1'b1;
        rand_r = 1'b1;
        for (int it = 0; it < 8; it++)
            run_burst($sformatf("rnd%0d", it), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 3)), 600);
        rand_v = 1'b0;
        rand_r = 1'b0;

        // Asynchronous reset mid-packet, then a fresh burst
        pkt_len = 16'd8;
        wr(A_PKTS, 32'd1);
        beats.delete();
        wr(A_CTRL, 32'h1);
        step();
        wait_beats("arst", 3, 40);
        @(negedge clk);
        chk("arst pre tvalid", 64'(o_tvalid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst o_tvalid",  64'(o_tvalid),  64'd0);
        chk("arst o_tlast",   64'(o_tlast),   64'd0);
        chk("arst o_eob",     64'(o_eob),     64'd0);
        chk("arst i_tready",  64'(i_tready),  64'd0);
        chk("arst busy",      64'(busy),      64'd0);
        chk("arst rb_status", 64'(rb_status), 64'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        beats.delete();
        base = data_ctr;
        // Registers are back at reset values: one packet per burst.
        wr(A_CTRL, 32'h1);
        step();
        wait_idle("arst", 40);
        expect_burst("arst", base, 8, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
